// File: rtl/decryption_unit.sv
// Two-stage shift-cipher decryption pipeline: alphabet subtract/add (mod 26), bit-rotate, or bypass.
// Optional macro ASCII_MODE_EN makes the mod-26 modes operate on ASCII letters, preserving case.
module decryption_unit #(
  parameter int N = 8  // >= 5, and >= 8 when ASCII_MODE_EN is defined
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] din,
  input  logic [4:0]   shift,
  input  logic [1:0]   direction,
  output logic [N-1:0] dout,
  output logic         v
);

  // Stage-1 registers
  logic [N-1:0] r_din;
  logic [1:0]   r_dir;
  logic [4:0]   r_s26;
  logic [4:0]   r_sn;
  logic         r_vld;

  logic [4:0]   w_s26;
  logic [4:0]   w_sn;
  logic [N-1:0] w_rot;
  logic [N-1:0] w_f;

  // Single correction step is enough because the reduced shift is always below 26.
  function automatic logic [4:0] shift26(input logic [4:0] idx, input logic [4:0] s,
                                         input logic add);
    logic [5:0] t;
    if (add) begin
      t = {1'b0, idx} + {1'b0, s};
      if (t >= 6'd26) t = t - 6'd26;
    end else begin
      t = {1'b0, idx} - {1'b0, s};
      if (t[5]) t = t + 6'd26;
    end
    return t[4:0];
  endfunction

  assign w_s26 = (shift >= 5'd26) ? (shift - 5'd26) : shift;
  assign w_sn  = 5'(32'(shift) % N);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_din <= '0;
      r_dir <= 2'b00;
      r_s26 <= 5'd0;
      r_sn  <= 5'd0;
      r_vld <= 1'b0;
    end else begin
      r_din <= din;
      r_dir <= direction;
      r_s26 <= w_s26;
      r_sn  <= w_sn;
      r_vld <= en;
    end
  end

  // A rotate amount of zero shifts the left term by N, which yields zero: identity.
  assign w_rot = (r_din >> r_sn) | (r_din << (N - 32'(r_sn)));

  always_comb begin
    w_f = r_din;
    case (r_dir)
      2'b00, 2'b10: begin
`ifdef ASCII_MODE_EN
        if (r_din >= N'('h41) && r_din <= N'('h5A))
          w_f = N'('h41) + N'(shift26(5'(r_din - N'('h41)), r_s26, r_dir[1]));
        else if (r_din >= N'('h61) && r_din <= N'('h7A))
          w_f = N'('h61) + N'(shift26(5'(r_din - N'('h61)), r_s26, r_dir[1]));
`else
        if (r_din < N'(26))
          w_f = N'(shift26(r_din[4:0], r_s26, r_dir[1]));
`endif
      end
      2'b01:   w_f = w_rot;
      default: w_f = r_din;
    endcase
  end

  // Output stage: dout only updates for valid symbols so it holds across idle cycles.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      dout <= '0;
      v    <= 1'b0;
    end else begin
      v <= r_vld;
      if (r_vld) dout <= w_f;
    end
  end

endmodule

// File: tb/tb_decryption_unit.sv
// Bench for decryption_unit: vector table plus scoreboard queue, with hand sequences for reset/enable.
// Inputs change and outputs are sampled on the falling edge; the design samples on the rising edge.
module tb_decryption_unit;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       en    = 1'b0;
  logic [7:0] din   = 8'h00;
  logic [4:0] shift = 5'd0;
  logic [1:0] direction = 2'b00;
  logic [7:0] dout;
  logic       v;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] din;
    logic [4:0] shift;
    logic [1:0] dir;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  decryption_unit #(.N(8)) dut (
    .clock(clock), .rst(rst), .en(en), .din(din), .shift(shift),
    .direction(direction), .dout(dout), .v(v)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Independent reference: plain integer modulo arithmetic.
  function automatic logic [7:0] model(input logic [7:0] d, input logic [4:0] sh,
                                       input logic [1:0] dir);
    int s, sn, r, di;
    di = int'(d);
    s  = int'(sh) % 26;
    sn = int'(sh) % 8;
    r  = di;
    case (dir)
      2'b00, 2'b10: begin
`ifdef ASCII_MODE_EN
        if (di >= 65 && di <= 90)
          r = 65 + ((dir == 2'b10) ? (di - 65 + s) % 26 : (di - 65 - s + 26) % 26);
        else if (di >= 97 && di <= 122)
          r = 97 + ((dir == 2'b10) ? (di - 97 + s) % 26 : (di - 97 - s + 26) % 26);
`else
        if (di < 26)
          r = (dir == 2'b10) ? (di + s) % 26 : (di - s + 26) % 26;
`endif
      end
      2'b01: r = ((di >> sn) | (di << (8 - sn))) & 255;
      default: r = di;
    endcase
    return 8'(r);
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic [4:0] sh,
                              input logic [1:0] dir, input logic [7:0] e);
    vec_t t;
    t.din = d; t.shift = sh; t.dir = dir; t.exp = e;
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_sym(input logic [7:0] d, input logic [4:0] sh,
                           input logic [1:0] dir, input logic [7:0] e);
    din = d; shift = sh; direction = dir; en = 1'b1;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle();
    en = 1'b0;
    din = 8'($urandom_range(0, 255));
    @(negedge clock);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (!rst && v) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 16'(v), 16'(0));
      end else begin
        check("dout_stream", 16'(dout), 16'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] held;
    logic [7:0] d;
    logic [4:0] sh;
    logic [1:0] dir;
    int budget;

    // Vector table
`ifndef ASCII_MODE_EN
    vecs.push_back(mk(8'h0B, 5'd15, 2'b00, 8'h16));
    vecs.push_back(mk(8'h0B, 5'd20, 2'b00, 8'h11));
    vecs.push_back(mk(8'h0B, 5'd25, 2'b00, 8'h0C));
    vecs.push_back(mk(8'h0B, 5'd26, 2'b00, 8'h0B));
    vecs.push_back(mk(8'h0B, 5'd1,  2'b00, 8'h0A));
    vecs.push_back(mk(8'h0B, 5'd0,  2'b00, 8'h0B));
    vecs.push_back(mk(8'h0B, 5'd5,  2'b10, 8'h10));
    vecs.push_back(mk(8'h0B, 5'd10, 2'b10, 8'h15));
    vecs.push_back(mk(8'h0B, 5'd15, 2'b10, 8'h00));
    vecs.push_back(mk(8'h0B, 5'd20, 2'b10, 8'h05));
    vecs.push_back(mk(8'h0B, 5'd25, 2'b10, 8'h0A));
    vecs.push_back(mk(8'h0B, 5'd26, 2'b10, 8'h0B));
    vecs.push_back(mk(8'h1F, 5'd3,  2'b00, 8'h1F));
    vecs.push_back(mk(8'h1A, 5'd3,  2'b10, 8'h1A));
    vecs.push_back(mk(8'h00, 5'd31, 2'b00, 8'h15));
    vecs.push_back(mk(8'h19, 5'd31, 2'b10, 8'h04));
`else
    vecs.push_back(mk(8'h41, 5'd1,  2'b00, 8'h5A));
    vecs.push_back(mk(8'h7A, 5'd1,  2'b10, 8'h61));
    vecs.push_back(mk(8'h20, 5'd1,  2'b00, 8'h20));
    vecs.push_back(mk(8'h20, 5'd1,  2'b10, 8'h20));
    vecs.push_back(mk(8'h61, 5'd27, 2'b00, 8'h7A));
    vecs.push_back(mk(8'h5A, 5'd26, 2'b10, 8'h5A));
    vecs.push_back(mk(8'h0B, 5'd5,  2'b00, 8'h0B));
`endif
    vecs.push_back(mk(8'h0B, 5'd1,  2'b01, 8'h85));
    vecs.push_back(mk(8'h0B, 5'd5,  2'b01, 8'h58));
    vecs.push_back(mk(8'h0B, 5'd10, 2'b01, 8'hC2));
    vecs.push_back(mk(8'h0B, 5'd8,  2'b01, 8'h0B));
    vecs.push_back(mk(8'h0B, 5'd16, 2'b01, 8'h0B));
    vecs.push_back(mk(8'h0B, 5'd20, 2'b11, 8'h0B));

    // Reset held with en=1: outputs stay cleared
    en = 1'b1; din = 8'hAA; shift = 5'd3; direction = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("reset_hold", {7'd0, v, dout}, 16'h0000);
    end

    // Release and first symbol: latency 2
    rst = 1'b0;
`ifndef ASCII_MODE_EN
    drive_sym(8'h0B, 5'd5, 2'b00, 8'h06);
`else
    drive_sym(8'h0B, 5'd5, 2'b00, 8'h0B);
`endif
    check("first_latency_v", 16'(v), 16'(0));

    // Table streamed back to back
    foreach (vecs[i]) drive_sym(vecs[i].din, vecs[i].shift, vecs[i].dir, vecs[i].exp);

    // Enable drop: v falls two clocks later, dout holds
    drive_sym(8'h0B, 5'd20, 2'b11, 8'h0B);
    held = 8'h0B;
    idle();
    idle();
    check("en_drop_v", 16'(v), 16'(0));
    check("en_drop_hold", 16'(dout), 16'(held));
    idle();
    check("en_drop_hold2", {7'd0, v, dout}, {8'd0, held});

    // Random traffic against the reference model, with occasional bubbles
    for (int i = 0; i < 40; i++) begin
      d   = (i % 2 == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
      sh  = 5'($urandom_range(0, 31));
      dir = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) idle();
      drive_sym(d, sh, dir, model(d, sh, dir));
    end

    // Reset pulse mid-stream: in-flight symbols discarded
    drive_sym(8'h05, 5'd2, 2'b10, model(8'h05, 5'd2, 2'b10));
    drive_sym(8'h06, 5'd2, 2'b10, model(8'h06, 5'd2, 2'b10));
    din = 8'h11; shift = 5'd4; direction = 2'b00; en = 1'b1;
    #2 rst = 1'b1;
    exp_q.delete();
    #1 check("rst_pulse_clear", {7'd0, v, dout}, 16'h0000);
    @(negedge clock);
    check("rst_pulse_hold", {7'd0, v, dout}, 16'h0000);
    #2 rst = 1'b0;
    exp_q.push_back(model(8'h11, 5'd4, 2'b00));
    @(negedge clock);
    check("rst_recover_v0", 16'(v), 16'(0));
    en = 1'b0;
    @(negedge clock);
    @(negedge clock);

    // Drain with a bounded wait
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clock);
      budget++;
    end
    check("drain_empty", 16'(exp_q.size()), 16'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
